// File: rtl/decoder_onehot_seq_if.sv
// Select/strobe bundle for the one-hot decoder: handshaked select in, registered one-hot out.
interface decoder_onehot_seq_if #(
    parameter int SEL_W = 2,
    parameter int OUT_W = 4
);
    logic             clr;
    logic [SEL_W-1:0] sel;
    logic             in_valid;
    logic             in_ready;
    logic             scan_start;
    logic             scan_loop;
    logic [OUT_W-1:0] dec_out;
    logic             out_valid;
    logic [SEL_W-1:0] cur_idx;
    logic             scan_done;
    logic             sel_err;

    modport slave (
        input  clr, sel, in_valid, scan_start, scan_loop,
        output in_ready, dec_out, out_valid, cur_idx, scan_done, sel_err
    );

    modport master (
        output clr, sel, in_valid, scan_start, scan_loop,
        input  in_ready, dec_out, out_valid, cur_idx, scan_done, sel_err
    );
endinterface

// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with a direct (handshaked) mode and an
// auto-walking scan mode that holds each output high for DWELL cycles.
module decoder_onehot_seq #(
    parameter int SEL_W = 2,
    parameter int OUT_W = 4,
    parameter int DWELL = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_onehot_seq_if.slave  bus
);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t           state_q;
    logic [OUT_W-1:0] dec_q;
    logic             vld_q;
    logic [SEL_W-1:0] idx_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic dwell_end;
    logic last_idx;
    logic sel_ok;

    assign dwell_end = (cnt_q == CNT_W'(DWELL - 1));
    assign last_idx  = (idx_q == SEL_W'(OUT_W - 1));
    // Codes at or above OUT_W exist only when OUT_W < 2**SEL_W.
    assign sel_ok    = (32'(bus.sel) < 32'(OUT_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dec_q   <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.clr) begin
                state_q <= IDLE;
                dec_q   <= '0;
                vld_q   <= 1'b0;
                idx_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE, HOLD: begin
                        if (bus.in_valid) begin
                            state_q <= HOLD;
                            if (sel_ok) begin
                                dec_q <= OUT_W'(1) << bus.sel;
                                vld_q <= 1'b1;
                                idx_q <= bus.sel;
                            end else begin
                                dec_q <= '0;
                                vld_q <= 1'b0;
                                err_q <= 1'b1;
                            end
                        end else if (bus.scan_start) begin
                            state_q <= SCAN;
                            dec_q   <= OUT_W'(1);
                            vld_q   <= 1'b1;
                            idx_q   <= '0;
                            cnt_q   <= '0;
                        end
                    end
                    SCAN: begin
                        if (dwell_end) begin
                            cnt_q <= '0;
                            if (last_idx) begin
                                done_q <= 1'b1;
                                idx_q  <= '0;
                                // Looping restarts at output 0 on the wrap edge itself, no gap.
                                if (bus.scan_loop) begin
                                    dec_q <= OUT_W'(1);
                                    vld_q <= 1'b1;
                                end else begin
                                    state_q <= IDLE;
                                    dec_q   <= '0;
                                    vld_q   <= 1'b0;
                                end
                            end else begin
                                dec_q <= dec_q << 1;
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (state_q != SCAN);
    assign bus.dec_out   = dec_q;
    assign bus.out_valid = vld_q;
    assign bus.cur_idx   = idx_q;
    assign bus.scan_done = done_q;
    assign bus.sel_err   = err_q;
endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Three decoder configurations driven by the same stimulus, each checked every cycle
// against a pass-position model of direct decode and scan behaviour.
module tb_decoder_onehot_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       scan_start = 1'b0;
    logic       scan_loop = 1'b0;
    logic [1:0] sel = 2'd0;

    always #5 clk = ~clk;

    decoder_onehot_seq_if #(.SEL_W(2), .OUT_W(4)) ifa ();
    decoder_onehot_seq_if #(.SEL_W(2), .OUT_W(4)) ifb ();
    decoder_onehot_seq_if #(.SEL_W(2), .OUT_W(3)) ifc ();

    assign ifa.clr = clr;  assign ifa.sel = sel;  assign ifa.in_valid = in_valid;
    assign ifa.scan_start = scan_start;  assign ifa.scan_loop = scan_loop;
    assign ifb.clr = clr;  assign ifb.sel = sel;  assign ifb.in_valid = in_valid;
    assign ifb.scan_start = scan_start;  assign ifb.scan_loop = scan_loop;
    assign ifc.clr = clr;  assign ifc.sel = sel;  assign ifc.in_valid = in_valid;
    assign ifc.scan_start = scan_start;  assign ifc.scan_loop = scan_loop;

    decoder_onehot_seq #(.SEL_W(2), .OUT_W(4), .DWELL(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    decoder_onehot_seq #(.SEL_W(2), .OUT_W(4), .DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    decoder_onehot_seq #(.SEL_W(2), .OUT_W(3), .DWELL(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    // Model: mode 0=idle, 1=hold, 2=scan; scan tracked as position within the pass.
    int ow [3] = '{4, 4, 3};
    int dw [3] = '{3, 1, 2};
    int m_st  [3];
    int m_pos [3];
    int m_idx [3];
    int m_dec [3];
    int m_done[3];
    int m_err [3];

    int n_vec = 0;
    int n_bad = 0;

    function automatic void m_clear(int m);
        m_st[m] = 0; m_pos[m] = 0; m_idx[m] = 0; m_dec[m] = 0;
        m_done[m] = 0; m_err[m] = 0;
    endfunction

    function automatic void m_reset();
        for (int m = 0; m < 3; m++) m_clear(m);
    endfunction

    function automatic void m_step();
        for (int m = 0; m < 3; m++) begin
            m_done[m] = 0;
            m_err[m]  = 0;
            if (clr) begin
                m_clear(m);
            end else if (m_st[m] != 2) begin
                if (in_valid) begin
                    m_st[m] = 1;
                    if (int'(sel) < ow[m]) begin
                        m_idx[m] = int'(sel);
                        m_dec[m] = 1 << sel;
                    end else begin
                        m_dec[m] = 0;
                        m_err[m] = 1;
                    end
                end else if (scan_start) begin
                    m_st[m] = 2; m_pos[m] = 0; m_idx[m] = 0; m_dec[m] = 1;
                end
            end else begin
                if (m_pos[m] == ow[m] * dw[m] - 1) begin
                    m_done[m] = 1;
                    m_pos[m]  = 0;
                    m_idx[m]  = 0;
                    if (scan_loop) m_dec[m] = 1;
                    else begin m_st[m] = 0; m_dec[m] = 0; end
                end else begin
                    m_pos[m] = m_pos[m] + 1;
                    m_idx[m] = m_pos[m] / dw[m];
                    m_dec[m] = 1 << m_idx[m];
                end
            end
        end
    endfunction

    task automatic cmp(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    task automatic chk_one(input int m, input logic [3:0] d, input logic v, input logic [1:0] ci,
                           input logic sd, input logic se, input logic rd);
        cmp("dec_out",   m, 32'(d),  32'(m_dec[m]));
        cmp("out_valid", m, 32'(v),  32'(m_dec[m] != 0));
        cmp("cur_idx",   m, 32'(ci), 32'(m_idx[m]));
        cmp("scan_done", m, 32'(sd), 32'(m_done[m]));
        cmp("sel_err",   m, 32'(se), 32'(m_err[m]));
        cmp("in_ready",  m, 32'(rd), 32'(m_st[m] != 2));
    endtask

    task automatic chk_all();
        chk_one(0, ifa.dec_out, ifa.out_valid, ifa.cur_idx, ifa.scan_done, ifa.sel_err, ifa.in_ready);
        chk_one(1, ifb.dec_out, ifb.out_valid, ifb.cur_idx, ifb.scan_done, ifb.sel_err, ifb.in_ready);
        chk_one(2, {1'b0, ifc.dec_out}, ifc.out_valid, ifc.cur_idx, ifc.scan_done, ifc.sel_err, ifc.in_ready);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        chk_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic arst();
        #2 rst = 1'b1;
        m_reset();
        #1;
        chk_all();
        cmp("rst_dec_now", 0, 32'(ifa.dec_out), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        m_reset();
        #3;
        chk_all();
        cmp("reset_dec", 0, 32'(ifa.dec_out), 32'd0);
        cmp("reset_rdy", 0, 32'(ifa.in_ready), 32'd1);
        rst = 1'b0;

        // Direct sweep 3,2,1,0 back-to-back; dut2 (OUT_W=3) flags code 3 then decodes 2.
        for (int s = 3; s >= 0; s--) begin
            sel = 2'(s);
            in_valid = 1'b1;
            tick();
            cmp("sweep_dec", 0, 32'(ifa.dec_out), 32'(1 << s));
        end
        in_valid = 1'b0;
        tick();

        // Single scan, with a mid-scan in_valid that must be ignored.
        scan_loop = 1'b0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            in_valid = (i == 5);
            sel = 2'd1;
            tick();
        end
        in_valid = 1'b0;

        // Looping scan, then drop scan_loop.
        scan_loop = 1'b1;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        repeat (20) tick();
        scan_loop = 1'b0;
        repeat (14) tick();

        // Synchronous clear mid-scan.
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();

        // Asynchronous reset while holding 0100.
        in_valid = 1'b1;
        sel = 2'd2;
        tick();
        in_valid = 1'b0;
        tick();
        arst();
        tick();

        // in_valid beats scan_start.
        in_valid = 1'b1;
        scan_start = 1'b1;
        sel = 2'd1;
        tick();
        in_valid = 1'b0;
        scan_start = 1'b0;
        tick();

        for (int k = 0; k < 3000; k++) begin
            clr        = ($urandom % 40) == 0;
            in_valid   = ($urandom % 4) == 0;
            sel        = 2'($urandom);
            scan_start = ($urandom % 12) == 0;
            if (($urandom % 50) == 0) scan_loop = ~scan_loop;
            tick();
            if (($urandom % 200) == 0) arst();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
